// File: rtl/legv8_multicycle_ctrl_pkg.sv
// Shared constants for the LEGv8 multicycle controller: state codes, opcode
// classes and the datapath select encodings also used by the immediate extender.
package legv8_multicycle_ctrl_pkg;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_ALU_EX = 4'd3;
    localparam logic [3:0] ST_ALU_WB = 4'd4;
    localparam logic [3:0] ST_ADDR   = 4'd5;
    localparam logic [3:0] ST_MEM_RD = 4'd6;
    localparam logic [3:0] ST_MEM_WR = 4'd7;
    localparam logic [3:0] ST_LD_WB  = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;

    typedef enum logic [3:0] {
        CLS_NONE  = 4'd0,
        CLS_R     = 4'd1,
        CLS_I     = 4'd2,
        CLS_LDUR  = 4'd3,
        CLS_STUR  = 4'd4,
        CLS_B     = 4'd5,
        CLS_CBZ   = 4'd6,
        CLS_CBNZ  = 4'd7,
        CLS_BCOND = 4'd8
    } opclass_t;

    localparam logic [1:0] ALUSRCA_PC     = 2'd0;
    localparam logic [1:0] ALUSRCA_OLDPC  = 2'd1;
    localparam logic [1:0] ALUSRCA_REG1   = 2'd2;

    localparam logic [1:0] ALUSRCB_REG2   = 2'd0;
    localparam logic [1:0] ALUSRCB_CONST4 = 2'd1;
    localparam logic [1:0] ALUSRCB_IMM    = 2'd2;
    localparam logic [1:0] ALUSRCB_ZERO   = 2'd3;

    localparam logic [1:0] ALUOP_ADD      = 2'd0;
    localparam logic [1:0] ALUOP_PASSB    = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE    = 2'd2;
    localparam logic [1:0] ALUOP_ITYPE    = 2'd3;

    localparam logic [2:0] IMMSEL_NONE    = 3'd0;
    localparam logic [2:0] IMMSEL_I       = 3'd1;
    localparam logic [2:0] IMMSEL_D       = 3'd2;
    localparam logic [2:0] IMMSEL_B       = 3'd3;
    localparam logic [2:0] IMMSEL_CB      = 3'd4;

    // Immediate format each class needs; the extender uses the same mapping.
    function automatic logic [2:0] imm_sel_of(input opclass_t cls);
        logic [2:0] sel;
        case (cls)
            CLS_I:                           sel = IMMSEL_I;
            CLS_LDUR, CLS_STUR:              sel = IMMSEL_D;
            CLS_B:                           sel = IMMSEL_B;
            CLS_CBZ, CLS_CBNZ, CLS_BCOND:    sel = IMMSEL_CB;
            default:                         sel = IMMSEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/legv8_opclass_decode.sv
// Combinational opcode-to-class map. Exact opcodes are matched before the
// shorter prefix formats so no pattern can shadow a more specific one.
module legv8_opclass_decode
    import legv8_multicycle_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output opclass_t    opclass
);

    always_comb begin
        opclass = CLS_NONE;
        casez (opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: opclass = CLS_R;
            11'b11111000010: opclass = CLS_LDUR;
            11'b11111000000: opclass = CLS_STUR;
            11'b1001000100?,
            11'b1101000100?,
            11'b1001001000?,
            11'b1011001000?: opclass = CLS_I;
            11'b10110100???: opclass = CLS_CBZ;
            11'b10110101???: opclass = CLS_CBNZ;
            11'b01010100???: opclass = CLS_BCOND;
            11'b000101?????: opclass = CLS_B;
            default:         opclass = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback,
// latches the opcode class in DECODE and counts retired instructions.
module legv8_multicycle_ctrl
    import legv8_multicycle_ctrl_pkg::*;
(
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [10:0] iOpcode,
    input  logic        iZero,
    input  logic        iCondTrue,
    input  logic        iMemReady,
    output logic        oIRWrite,
    output logic        oPCWrite,
    output logic        oPCWriteCond,
    output logic        oOldPCWrite,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic        oRegWrite,
    output logic [1:0]  oALUSrcA,
    output logic [1:0]  oALUSrcB,
    output logic [1:0]  oALUOp,
    output logic [2:0]  oImmSel,
    output logic        oMemToReg,
    output logic        oPCSource,
    output logic        oIllegal,
    output logic [31:0] oInstret
);

    logic [3:0]  state_q, state_d;
    opclass_t    class_q, class_d;
    logic [31:0] instret_q, instret_d;
    opclass_t    dec_class;
    logic        retire;

    legv8_opclass_decode u_decode (
        .opcode  (iOpcode),
        .opclass (dec_class)
    );

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        retire       = 1'b0;
        oIRWrite     = 1'b0;
        oPCWrite     = 1'b0;
        oPCWriteCond = 1'b0;
        oOldPCWrite  = 1'b0;
        oMemRead     = 1'b0;
        oMemWrite    = 1'b0;
        oRegWrite    = 1'b0;
        oALUSrcA     = ALUSRCA_PC;
        oALUSrcB     = ALUSRCB_REG2;
        oALUOp       = ALUOP_ADD;
        oImmSel      = IMMSEL_NONE;
        oMemToReg    = 1'b0;
        oPCSource    = 1'b0;
        oIllegal     = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                oMemRead    = 1'b1;
                oIRWrite    = 1'b1;
                oOldPCWrite = 1'b1;
                oALUSrcB    = ALUSRCB_CONST4;
                if (iMemReady) begin
                    oPCWrite = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            // The IR was written at the end of FETCH, so iOpcode is valid here.
            ST_DECODE: begin
                oALUSrcA = ALUSRCA_OLDPC;
                oALUSrcB = ALUSRCB_IMM;
                oImmSel  = imm_sel_of(dec_class);
                class_d  = dec_class;
                case (dec_class)
                    CLS_R, CLS_I:                       state_d = ST_ALU_EX;
                    CLS_LDUR, CLS_STUR:                 state_d = ST_ADDR;
                    CLS_B, CLS_CBZ, CLS_CBNZ, CLS_BCOND: state_d = ST_BRANCH;
                    default: begin
                        oIllegal = 1'b1;
                        state_d  = ST_FETCH;
                    end
                endcase
            end
            ST_ALU_EX: begin
                oALUSrcA = ALUSRCA_REG1;
                if (class_q == CLS_I) begin
                    oALUSrcB = ALUSRCB_IMM;
                    oImmSel  = IMMSEL_I;
                    oALUOp   = ALUOP_ITYPE;
                end else begin
                    oALUOp   = ALUOP_RTYPE;
                end
                state_d = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                oRegWrite = 1'b1;
                oImmSel   = (class_q == CLS_I) ? IMMSEL_I : IMMSEL_NONE;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_ADDR: begin
                oALUSrcA = ALUSRCA_REG1;
                oALUSrcB = ALUSRCB_IMM;
                oImmSel  = IMMSEL_D;
                state_d  = (class_q == CLS_STUR) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                oMemRead = 1'b1;
                if (iMemReady) state_d = ST_LD_WB;
            end
            ST_LD_WB: begin
                oRegWrite = 1'b1;
                oMemToReg = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_MEM_WR: begin
                oMemWrite = 1'b1;
                if (iMemReady) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                oPCSource = 1'b1;
                case (class_q)
                    CLS_B:     oPCWrite = 1'b1;
                    CLS_BCOND: oPCWrite = iCondTrue;
                    CLS_CBZ, CLS_CBNZ: begin
                        oALUSrcA     = ALUSRCA_REG1;
                        oALUSrcB     = ALUSRCB_REG2;
                        oALUOp       = ALUOP_PASSB;
                        oPCWriteCond = 1'b1;
                        oPCWrite     = (class_q == CLS_CBZ) ? iZero : !iZero;
                    end
                    default:   oPCWrite = 1'b0;
                endcase
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            class_q   <= CLS_NONE;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            instret_q <= instret_d;
        end
    end

    assign oInstret = instret_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: directed scenarios plus random instruction
// streams, each checked cycle by cycle against a per-instruction schedule model.
module tb_legv8_multicycle_ctrl;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [10:0] iOpcode = '0;
    logic        iZero = 1'b0;
    logic        iCondTrue = 1'b0;
    logic        iMemReady = 1'b0;
    logic        oIRWrite, oPCWrite, oPCWriteCond, oOldPCWrite;
    logic        oMemRead, oMemWrite, oRegWrite, oMemToReg, oPCSource, oIllegal;
    logic [1:0]  oALUSrcA, oALUSrcB, oALUOp;
    logic [2:0]  oImmSel;
    logic [31:0] oInstret;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_instret = '0;

    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4,
                   C_B = 5, C_CBZ = 6, C_CBNZ = 7, C_BC = 8;

    legv8_multicycle_ctrl dut (
        .iCLK(iCLK), .iRST(iRST), .iOpcode(iOpcode), .iZero(iZero),
        .iCondTrue(iCondTrue), .iMemReady(iMemReady),
        .oIRWrite(oIRWrite), .oPCWrite(oPCWrite), .oPCWriteCond(oPCWriteCond),
        .oOldPCWrite(oOldPCWrite), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
        .oRegWrite(oRegWrite), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB),
        .oALUOp(oALUOp), .oImmSel(oImmSel), .oMemToReg(oMemToReg),
        .oPCSource(oPCSource), .oIllegal(oIllegal), .oInstret(oInstret)
    );

    always #5 iCLK = ~iCLK;

    logic [31:0] obs;
    assign obs = {13'b0, oIRWrite, oPCWrite, oPCWriteCond, oOldPCWrite, oMemRead,
                  oMemWrite, oRegWrite, oALUSrcA, oALUSrcB, oALUOp, oImmSel,
                  oMemToReg, oPCSource, oIllegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ev(
        input logic irw, pcw, pcwc, opw, mr, mw, rw,
        input logic [1:0] sa, sb, aop, input logic [2:0] imm,
        input logic m2r, pcs, ill);
        return {13'b0, irw, pcw, pcwc, opw, mr, mw, rw, sa, sb, aop, imm, m2r, pcs, ill};
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Instruction classes from the LEGv8 opcode table.
    function automatic int classify(input logic [10:0] op);
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return C_R;
        if (op == 11'b11111000010) return C_LD;
        if (op == 11'b11111000000) return C_ST;
        if (op ==? 11'b1001000100? || op ==? 11'b1101000100? ||
            op ==? 11'b1001001000? || op ==? 11'b1011001000?) return C_I;
        if (op ==? 11'b10110100???) return C_CBZ;
        if (op ==? 11'b10110101???) return C_CBNZ;
        if (op ==? 11'b01010100???) return C_BC;
        if (op ==? 11'b000101?????) return C_B;
        return C_ILL;
    endfunction

    function automatic logic [2:0] imm_for(input int c);
        case (c)
            C_I:              return 3'd1;
            C_LD, C_ST:       return 3'd2;
            C_B:              return 3'd3;
            C_CBZ, C_CBNZ, C_BC: return 3'd4;
            default:          return 3'd0;
        endcase
    endfunction

    // Drive this cycle's inputs mid-cycle, check outputs, then ride the edge.
    task automatic step(input string tag, input logic rdy, input logic z,
                        input logic c, input logic [31:0] exp);
        @(negedge iCLK);
        iMemReady = rdy; iZero = z; iCondTrue = c;
        #1 chk(tag, obs, exp);
        @(posedge iCLK);
    endtask

    task automatic run_instr(input logic [10:0] opc, input int fw, input int mw,
                             input logic z, input logic c);
        int cls;
        logic [31:0] e_fetch;
        cls = classify(opc);
        iOpcode = opc;
        e_fetch = ev(1,0,0,1,1,0,0, 2'd0,2'd1,2'd0, 3'd0, 0,0,0);
        for (int k = 0; k < fw; k++) step("fetch_wait", 1'b0, rb(), rb(), e_fetch);
        step("fetch", 1'b1, rb(), rb(), e_fetch | ev(0,1,0,0,0,0,0, 0,0,0, 0, 0,0,0));
        step("decode", rb(), rb(), rb(),
             ev(0,0,0,0,0,0,0, 2'd1,2'd2,2'd0, imm_for(cls), 0,0, cls == C_ILL));
        #1 iOpcode = 11'($urandom);
        case (cls)
            C_R: begin
                step("alu_ex_r", rb(), rb(), rb(), ev(0,0,0,0,0,0,0, 2'd2,2'd0,2'd2, 3'd0, 0,0,0));
                step("alu_wb_r", rb(), rb(), rb(), ev(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0, 0,0,0));
            end
            C_I: begin
                step("alu_ex_i", rb(), rb(), rb(), ev(0,0,0,0,0,0,0, 2'd2,2'd2,2'd3, 3'd1, 0,0,0));
                step("alu_wb_i", rb(), rb(), rb(), ev(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd1, 0,0,0));
            end
            C_LD, C_ST: begin
                logic [31:0] e_mem;
                step("addr", rb(), rb(), rb(), ev(0,0,0,0,0,0,0, 2'd2,2'd2,2'd0, 3'd2, 0,0,0));
                e_mem = (cls == C_LD) ? ev(0,0,0,0,1,0,0, 0,0,0, 0, 0,0,0)
                                      : ev(0,0,0,0,0,1,0, 0,0,0, 0, 0,0,0);
                for (int k = 0; k < mw; k++) step("mem_wait", 1'b0, rb(), rb(), e_mem);
                step("mem_done", 1'b1, rb(), rb(), e_mem);
                if (cls == C_LD)
                    step("ld_wb", rb(), rb(), rb(), ev(0,0,0,0,0,0,1, 0,0,0, 0, 1,0,0));
            end
            C_B:   step("br_b", rb(), z, c, ev(0,1,0,0,0,0,0, 0,0,0, 0, 0,1,0));
            C_BC:  step("br_cond", rb(), z, c, ev(0,c,0,0,0,0,0, 0,0,0, 0, 0,1,0));
            C_CBZ, C_CBNZ:
                step("br_cb", rb(), z, c,
                     ev(0, (cls == C_CBZ) ? z : !z, 1,0,0,0,0, 2'd2,2'd0,2'd1, 3'd0, 0,1,0));
            default: ;
        endcase
        if (cls != C_ILL) model_instret = model_instret + 32'd1;
        #1 chk("instret", oInstret, model_instret);
    endtask

    task automatic release_reset();
        iRST = 1'b0;
        model_instret = '0;
        step("idle", rb(), rb(), rb(), 32'd0);
    endtask

    function automatic logic [10:0] rand_opc(input int cls);
        logic [10:0] r;
        r = 11'($urandom);
        case (cls)
            C_R: case ($urandom_range(0, 3))
                    0: return 11'b10001011000;
                    1: return 11'b11001011000;
                    2: return 11'b10001010000;
                    default: return 11'b10101010000;
                 endcase
            C_I: case ($urandom_range(0, 3))
                    0: return 11'b10010001000 | (r & 11'h001);
                    1: return 11'b11010001000 | (r & 11'h001);
                    2: return 11'b10010010000 | (r & 11'h001);
                    default: return 11'b10110010000 | (r & 11'h001);
                 endcase
            C_LD:   return 11'b11111000010;
            C_ST:   return 11'b11111000000;
            C_B:    return 11'b00010100000 | (r & 11'h01F);
            C_CBZ:  return 11'b10110100000 | (r & 11'h007);
            C_CBNZ: return 11'b10110101000 | (r & 11'h007);
            C_BC:   return 11'b01010100000 | (r & 11'h007);
            default: begin
                for (int k = 0; k < 100; k++) begin
                    if (classify(r) == C_ILL) return r;
                    r = 11'($urandom);
                end
                return 11'b00000000000;
            end
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_outs", obs, 32'd0);
        chk("rst_instret", oInstret, 32'd0);
        release_reset();

        run_instr(11'b10001011000, 0, 0, 1'b0, 1'b0);
        chk("add_instret1", oInstret, 32'd1);
        run_instr(11'b11111000010, 0, 2, 1'b0, 1'b0);
        run_instr(11'b10110100101, 0, 0, 1'b1, 1'b0);
        run_instr(11'b10110100011, 0, 0, 1'b0, 1'b0);
        run_instr(11'b00000000000, 0, 0, 1'b0, 1'b0);
        run_instr(11'b01010100000, 1, 0, 1'b0, 1'b1);

        // Counter wrap: preload the retire counter, then retire a B.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        model_instret = 32'hFFFF_FFFF;
        chk("preload", oInstret, 32'hFFFF_FFFF);
        run_instr(11'b00010100111, 0, 0, 1'b0, 1'b0);
        chk("wrap", oInstret, 32'd0);

        // Reset arriving while a store waits on memory.
        iOpcode = 11'b11111000000;
        step("st_fetch", 1'b1, 0, 0, ev(1,1,0,1,1,0,0, 2'd0,2'd1,2'd0, 3'd0, 0,0,0));
        step("st_decode", 1'b1, 0, 0, ev(0,0,0,0,0,0,0, 2'd1,2'd2,2'd0, 3'd2, 0,0,0));
        step("st_addr", 1'b1, 0, 0, ev(0,0,0,0,0,0,0, 2'd2,2'd2,2'd0, 3'd2, 0,0,0));
        step("st_memwr", 1'b0, 0, 0, ev(0,0,0,0,0,1,0, 0,0,0, 0, 0,0,0));
        @(negedge iCLK);
        iMemReady = 1'b1; iRST = 1'b1;
        #1 chk("st_memwr_hold", obs, ev(0,0,0,0,0,1,0, 0,0,0, 0, 0,0,0));
        @(posedge iCLK);
        #1;
        chk("rst_memwr_outs", obs, 32'd0);
        chk("rst_memwr_instret", oInstret, 32'd0);
        release_reset();

        for (int n = 0; n < 80; n++) begin
            int cls;
            cls = $urandom_range(0, 8);
            run_instr(rand_opc(cls), $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
